down_counter8_to0: RTL

Loadable 8-bit down-counter/timer that counts a programmed value down to zero and reports terminal count. It produces the zero condition that the library's 8-input zero comparator only observes. It sits alongside the gate-level primitives as the sequential timing element for delays, timeouts and periodic ticks. The zero flag is the NOR of all count bits. Terminal count also raises a registered one-cycle `done` pulse and can optionally reload for periodic operation.

---
 rtl/down_counter8_to0.sv | 87 ++++++++
 1 files changed

// File: rtl/down_counter8_to0.sv
// rtl/down_counter8_to0.sv - loadable down-counter/timer with terminal-count done pulse and optional auto-reload
module down_counter8_to0 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             zero,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_n;
    logic [WIDTH-1:0] count_q, count_n;
    logic [WIDTH-1:0] reload_q, reload_n;
    logic             done_q, done_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            count_q  <= count_n;
            reload_q <= reload_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        count_n  = count_q;
        reload_n = reload_q;
        done_n   = 1'b0;
        if (load) begin
            count_n  = load_val;
            reload_n = load_val;
            // A zero load while running cancels the timer silently.
            if (state == RUN && load_val == '0) begin
                state_n = IDLE;
            end
        end else if (stop) begin
            state_n = IDLE;
        end else if (state == IDLE) begin
            if (start) begin
                if (count_q != '0) begin
                    state_n = RUN;
                end else begin
                    done_n = 1'b1;
                end
            end
        end else begin
            if (count_q > ONE) begin
                count_n = count_q - ONE;
            end else begin
                // Terminal count: reload only if there is something nonzero to reload.
                done_n = 1'b1;
                if (auto_reload && reload_q != '0) begin
                    count_n = reload_q;
                end else begin
                    count_n = '0;
                    state_n = IDLE;
                end
            end
        end
    end

    assign count = count_q;
    assign busy  = (state == RUN);
    assign zero  = ~|count_q;
    assign done  = done_q;

endmodule
